// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and helpers for the PLL reset sequencer
package pll_seq_pkg;

  localparam int RELOCK_CNT_W = 8;

  typedef enum logic [3:0] {
    ST_PLLRST   = 4'b0001,
    ST_WAITLOCK = 4'b0010,
    ST_STABLE   = 4'b0100,
    ST_RUN      = 4'b1000
  } state_e;

  // Width of the shared sequencing counter: enough to hold the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchronizer with asynchronous reset
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops resolve metastability on the incoming signal.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset / lock-wait / system reset release sequencer
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 64,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked_i,
  input  logic                    relock_req_i,
  output logic                    pll_rst_o,
  output logic                    sys_reset_o,
  output logic                    sys_ready_o,
  output logic [RELOCK_CNT_W-1:0] relock_count_o,
  output logic                    timeout_o
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);

  logic                    lk;
  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RELOCK_CNT_W-1:0] relock_cnt_q, relock_cnt_d;
  logic                    timeout_q, timeout_d;
  logic                    bump;
  logic                    pll_rst_q, pll_rst_d;
  logic                    sys_reset_q, sys_reset_d;
  logic                    sys_ready_q, sys_ready_d;

  sync2 #(.W(1)) u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked_i),
    .q_o   (lk)
  );

  // State register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state_q <= ST_PLLRST;
    else     state_q <= state_d;
  end

  // Next-state logic; a software request overrides every other transition.
  always_comb begin
    state_d   = state_q;
    bump      = 1'b0;
    timeout_d = timeout_q;
    if (relock_req_i) begin
      state_d = ST_PLLRST;
    end else begin
      case (state_q)
        ST_PLLRST: begin
          if (cnt_q == RST_LAST) state_d = ST_WAITLOCK;
        end
        ST_WAITLOCK: begin
          if (lk) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TO_LAST) begin
            state_d   = ST_PLLRST;
            bump      = 1'b1;
            timeout_d = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lk)                    state_d = ST_WAITLOCK;
          else if (cnt_q == STB_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lk) begin
            state_d = ST_PLLRST;
            bump    = 1'b1;
          end
        end
        default: state_d = ST_PLLRST;
      endcase
    end
  end

  // Output and datapath next values, derived from the upcoming state so that
  // every output can be taken straight from a flop.
  always_comb begin
    pll_rst_d   = (state_d == ST_PLLRST);
    sys_reset_d = (state_d != ST_RUN);
    sys_ready_d = (state_d == ST_RUN);
    if (relock_req_i || (state_d != state_q) || (state_q == ST_RUN)) cnt_d = '0;
    else                                                              cnt_d = cnt_q + 1'b1;
    if (bump && (relock_cnt_q != '1)) relock_cnt_d = relock_cnt_q + 1'b1;
    else                              relock_cnt_d = relock_cnt_q;
  end

  // Counter, statistics and output registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      relock_cnt_q <= '0;
      timeout_q    <= 1'b0;
      pll_rst_q    <= 1'b1;
      sys_reset_q  <= 1'b1;
      sys_ready_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      relock_cnt_q <= relock_cnt_d;
      timeout_q    <= timeout_d;
      pll_rst_q    <= pll_rst_d;
      sys_reset_q  <= sys_reset_d;
      sys_ready_q  <= sys_ready_d;
    end
  end

  assign pll_rst_o      = pll_rst_q;
  assign sys_reset_o    = sys_reset_q;
  assign sys_ready_o    = sys_ready_q;
  assign relock_count_o = relock_cnt_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - directed self-checking bench for pll_reset_seq
module tb_pll_reset_seq;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked_i;
  logic       relock_req_i;
  logic       pll_rst_o;
  logic       sys_reset_o;
  logic       sys_ready_o;
  logic [7:0] relock_count_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  pll_reset_seq #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked_i   (pll_locked_i),
    .relock_req_i   (relock_req_i),
    .pll_rst_o      (pll_rst_o),
    .sys_reset_o    (sys_reset_o),
    .sys_ready_o    (sys_ready_o),
    .relock_count_o (relock_count_o),
    .timeout_o      (timeout_o)
  );

  always #5 refclk = ~refclk;

  task automatic next_cycle();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with rst just released: cycle 0.
  task automatic do_reset();
    rst          = 1'b1;
    pll_locked_i = 1'b0;
    relock_req_i = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    pll_locked_i = 1'b0;
    relock_req_i = 1'b0;
    next_cycle();
    total++;
    if ({pll_rst_o, sys_reset_o, sys_ready_o, timeout_o} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=1100", {pll_rst_o, sys_reset_o, sys_ready_o, timeout_o});
    end
    total++;
    if (relock_count_o !== 8'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", relock_count_o);
    end
  endtask

  task automatic test_powerup();
    do_reset();
    for (int c = 0; c < 26; c++) begin
      if (c == 10) pll_locked_i = 1'b1;
      total++;
      if (pll_rst_o !== (c < 4)) begin
        bad++;
        $display("FAIL pwr_pll_rst c=%0d got=%0b exp=%0b", c, pll_rst_o, (c < 4));
      end
      total++;
      if (sys_reset_o !== (c < 21)) begin
        bad++;
        $display("FAIL pwr_sys_reset c=%0d got=%0b exp=%0b", c, sys_reset_o, (c < 21));
      end
      total++;
      if (sys_ready_o !== (c >= 21)) begin
        bad++;
        $display("FAIL pwr_sys_ready c=%0d got=%0b exp=%0b", c, sys_ready_o, (c >= 21));
      end
      next_cycle();
    end
    total++;
    if (relock_count_o !== 8'd0) begin
      bad++;
      $display("FAIL pwr_count got=%0d exp=0", relock_count_o);
    end
  endtask

  task automatic test_never_lock();
    do_reset();
    for (int c = 0; c < 110; c++) begin
      total++;
      if (pll_rst_o !== ((c % 36) < 4)) begin
        bad++;
        $display("FAIL nolock_pll_rst c=%0d got=%0b exp=%0b", c, pll_rst_o, ((c % 36) < 4));
      end
      total++;
      if (timeout_o !== (c >= 36)) begin
        bad++;
        $display("FAIL nolock_timeout c=%0d got=%0b exp=%0b", c, timeout_o, (c >= 36));
      end
      total++;
      if (relock_count_o !== 8'(c / 36)) begin
        bad++;
        $display("FAIL nolock_count c=%0d got=%0d exp=%0d", c, relock_count_o, c / 36);
      end
      next_cycle();
    end
  endtask

  task automatic test_glitch_stable();
    do_reset();
    for (int c = 0; c < 33; c++) begin
      if (c == 10) pll_locked_i = 1'b1;
      if (c == 17) pll_locked_i = 1'b0;
      if (c == 18) pll_locked_i = 1'b1;
      total++;
      if (sys_reset_o !== (c < 29)) begin
        bad++;
        $display("FAIL glitch_sys_reset c=%0d got=%0b exp=%0b", c, sys_reset_o, (c < 29));
      end
      next_cycle();
    end
    total++;
    if (relock_count_o !== 8'd0) begin
      bad++;
      $display("FAIL glitch_count got=%0d exp=0", relock_count_o);
    end
  endtask

  task automatic test_loss_in_run();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      if (c == 10) pll_locked_i = 1'b1;
      if (c == 30) pll_locked_i = 1'b0;
      if (c == 34) pll_locked_i = 1'b1;
      if (c == 32) begin
        total++;
        if (sys_reset_o !== 1'b0) begin
          bad++;
          $display("FAIL loss_n2_sys_reset got=%0b exp=0", sys_reset_o);
        end
      end
      if (c == 33) begin
        total++;
        if ({pll_rst_o, sys_reset_o, sys_ready_o} !== 3'b110) begin
          bad++;
          $display("FAIL loss_n3_outputs got=%b exp=110", {pll_rst_o, sys_reset_o, sys_ready_o});
        end
        total++;
        if (relock_count_o !== 8'd1) begin
          bad++;
          $display("FAIL loss_count got=%0d exp=1", relock_count_o);
        end
      end
      if (c == 45 || c == 46) begin
        total++;
        if (sys_reset_o !== (c == 45)) begin
          bad++;
          $display("FAIL loss_rerelease c=%0d got=%0b exp=%0b", c, sys_reset_o, (c == 45));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_sw_request();
    do_reset();
    for (int c = 0; c < 48; c++) begin
      if (c == 10) pll_locked_i = 1'b1;
      relock_req_i = (c == 30);
      if (c == 30) begin
        total++;
        if (sys_reset_o !== 1'b0) begin
          bad++;
          $display("FAIL req_before got=%0b exp=0", sys_reset_o);
        end
      end
      if (c == 31) begin
        total++;
        if ({pll_rst_o, sys_reset_o, sys_ready_o} !== 3'b110) begin
          bad++;
          $display("FAIL req_n1_outputs got=%b exp=110", {pll_rst_o, sys_reset_o, sys_ready_o});
        end
      end
      if (c == 34 || c == 35) begin
        total++;
        if (pll_rst_o !== (c == 34)) begin
          bad++;
          $display("FAIL req_pulse_end c=%0d got=%0b exp=%0b", c, pll_rst_o, (c == 34));
        end
      end
      if (c == 43 || c == 44) begin
        total++;
        if (sys_reset_o !== (c == 43)) begin
          bad++;
          $display("FAIL req_release c=%0d got=%0b exp=%0b", c, sys_reset_o, (c == 43));
        end
      end
      next_cycle();
    end
    relock_req_i = 1'b0;
    total++;
    if (relock_count_o !== 8'd0) begin
      bad++;
      $display("FAIL req_count got=%0d exp=0", relock_count_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      relock_req_i = (c == 2);
      total++;
      if (pll_rst_o !== (c < 7)) begin
        bad++;
        $display("FAIL restart_pulse c=%0d got=%0b exp=%0b", c, pll_rst_o, (c < 7));
      end
      next_cycle();
    end
    relock_req_i = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c <= 36 * 300 + 10; c++) begin
      if (c == 36 * 254 || c == 36 * 255 || c == 36 * 300) begin
        total++;
        if (relock_count_o !== ((c == 36 * 254) ? 8'd254 : 8'd255)) begin
          bad++;
          $display("FAIL sat_count c=%0d got=%0d", c, relock_count_o);
        end
      end
      if (c == 36 * 300 + 10) begin
        total++;
        if ({pll_rst_o, sys_reset_o, timeout_o} !== 3'b011) begin
          bad++;
          $display("FAIL sat_waitlock got=%b exp=011", {pll_rst_o, sys_reset_o, timeout_o});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pll_rst_o, sys_reset_o, sys_ready_o, timeout_o} !== 4'b1100) begin
          bad++;
          $display("FAIL async_rst_flags got=%b exp=1100", {pll_rst_o, sys_reset_o, sys_ready_o, timeout_o});
        end
        total++;
        if (relock_count_o !== 8'd0) begin
          bad++;
          $display("FAIL async_rst_count got=%0d exp=0", relock_count_o);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    pll_locked_i = 1'b0;
    relock_req_i = 1'b0;
    test_reset();
    test_powerup();
    test_never_lock();
    test_glitch_stable();
    test_loss_in_run();
    test_sw_request();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
